// File: rtl/alu_cmd_ctrl.sv
// Command sequencer around an external 16-bit combinational ALU: one command at a time,
// 4x16 register file, sticky flags, and a 16-step shift-add multiply through the ALU adder.
module alu_cmd_ctrl #(
    parameter logic MUL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [1:0]  cmd_dst,
    input  logic [1:0]  cmd_sa,
    input  logic [1:0]  cmd_sb,
    input  logic [15:0] cmd_imm,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [2:0]  rsp_flags,
    output logic        rsp_err,
    output logic [15:0] alu_opA,
    output logic [15:0] alu_opB,
    output logic [1:0]  alu_sel,
    input  logic [15:0] alu_res,
    input  logic        alu_c,
    input  logic        alu_z,
    input  logic        alu_o,
    output logic [2:0]  flags_q
);

    localparam int DATA_W = 16;
    localparam logic [2:0] OP_LDI = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic [2:0]        flags_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]        rsp_flags_q, rsp_flags_d;
    logic              rsp_err_q, rsp_err_d;

    logic [2:0]        op_q, op_d;
    logic [1:0]        dst_q, dst_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
    logic [3:0]        iter_q, iter_d;
    logic              cacc_q, cacc_d;

    logic              mul_legal;
    logic [2:0]        res_flags;

    assign mul_legal = MUL_EN && (cmd_op == OP_MUL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (!cmd_op[2])     state_d = S_EXEC;
                    else if (mul_legal) state_d = S_MUL;
                    else                state_d = S_RESP;
                end
            end
            S_EXEC:  state_d = S_RESP;
            S_MUL:   if (iter_q == 4'd15) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_data  = rsp_data_q;
        rsp_flags = rsp_flags_q;
        rsp_err   = rsp_err_q;
        alu_opA   = '0;
        alu_opB   = '0;
        alu_sel   = 2'b00;
        if (state_q == S_EXEC) begin
            alu_opA = opa_q;
            alu_opB = opb_q;
            alu_sel = op_q[1:0];
        end else if (state_q == S_MUL) begin
            alu_opA = acc_q;
            alu_opB = mplier_q[0] ? mcand_q : '0;
        end
    end

    always_comb begin
        regs_d      = regs_q;
        flags_d     = flags_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        op_d        = op_q;
        dst_d       = dst_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        iter_d      = iter_q;
        cacc_d      = cacc_q;
        res_flags   = 3'b000;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    dst_d    = cmd_dst;
                    opa_d    = regs_q[cmd_sa];
                    opb_d    = regs_q[cmd_sb];
                    acc_d    = '0;
                    mcand_d  = regs_q[cmd_sa];
                    mplier_d = regs_q[cmd_sb];
                    iter_d   = '0;
                    cacc_d   = 1'b0;
                    if (cmd_op == OP_LDI) begin
                        regs_d[cmd_dst] = cmd_imm;
                        rsp_data_d      = cmd_imm;
                        rsp_flags_d     = flags_q;
                        rsp_err_d       = 1'b0;
                    end else if (cmd_op[2] && !mul_legal) begin
                        rsp_data_d  = '0;
                        rsp_flags_d = flags_q;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                // Logic ops (op[1]=1) never report carry or overflow.
                res_flags     = {~op_q[1] & alu_c, alu_z, ~op_q[1] & alu_o};
                regs_d[dst_q] = alu_res;
                flags_d       = res_flags;
                rsp_data_d    = alu_res;
                rsp_flags_d   = res_flags;
                rsp_err_d     = 1'b0;
            end
            S_MUL: begin
                acc_d    = alu_res;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cacc_d   = cacc_q | alu_c;
                iter_d   = iter_q + 4'd1;
                // The last step's sum is the product; commit it on the same edge.
                if (iter_q == 4'd15) begin
                    res_flags     = {cacc_q | alu_c, alu_res == 16'd0, 1'b0};
                    regs_d[dst_q] = alu_res;
                    flags_d       = res_flags;
                    rsp_data_d    = alu_res;
                    rsp_flags_d   = res_flags;
                    rsp_err_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            flags_q     <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            flags_q     <= flags_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Working operands are always loaded at accept before use, so they carry no reset.
    always_ff @(posedge clk) begin
        op_q     <= op_d;
        dst_q    <= dst_d;
        opa_q    <= opa_d;
        opb_q    <= opb_d;
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        iter_q   <= iter_d;
        cacc_q   <= cacc_d;
    end

endmodule
